// File: rtl/sun_pll_pkg.sv
// sun_pll_pkg: shared state encoding and default parameters for the PLL
// lock controller (sun_pll_ctrl, sun_pll_tglsync).
package sun_pll_pkg;

  localparam int WIN_CYC_DEF     = 256;
  localparam int CNT_W_DEF       = 12;
  localparam int SETTLE_CYC_DEF  = 1024;
  localparam int LOCK_CONSEC_DEF = 4;
  localparam int MAX_WIN_DEF     = 64;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_MEASURE,
    ST_LOCK,
    ST_FAIL
  } pll_state_e;

  // Bits needed to hold any value 0..v (at least one bit)
  function automatic int bits_for(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/sun_pll_tglsync.sv
// sun_pll_tglsync: brings the asynchronous prescaler toggle into the reference
// clock domain and flags every transition (rising or falling) as one pulse.
module sun_pll_tglsync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic edge_o
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  // Shift the toggle through the synchronizer and history flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tgl_i};
    end
  end

  assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/sun_pll_ctrl.sv
// sun_pll_ctrl: PLL power-up / frequency-lock controller. Counts prescaler
// edges over fixed reference windows and declares lock after enough
// consecutive in-tolerance windows, or failure after too many windows.
// Optional build macro: SUN_PLL_CTRL_RELOCK_EN (lock is re-evaluated every
// window and a bad window returns to MEASURE); undefined, lock is sticky.
module sun_pll_ctrl
  import sun_pll_pkg::*;
#(
  parameter int WIN_CYC     = WIN_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int LOCK_CONSEC = LOCK_CONSEC_DEF,
  parameter int MAX_WIN     = MAX_WIN_DEF
) (
  input  logic             CK_REF,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIV_TGL,
  input  logic [CNT_W-1:0] TARGET,
  input  logic [CNT_W-1:0] TOL,
  output logic             PWRUP_1V8,
  output logic             LOCKED,
  output logic             FAIL,
  output logic [CNT_W-1:0] CNT_LAST
);

  localparam int WIN_W  = bits_for(WIN_CYC - 1);
  localparam int SET_W  = bits_for(SETTLE_CYC - 1);
  localparam int PASS_W = bits_for(LOCK_CONSEC);
  localparam int LIM_W  = bits_for(MAX_WIN);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [PASS_W-1:0] PASS_N   = PASS_W'(LOCK_CONSEC);
  localparam logic [LIM_W-1:0]  LIM_N    = LIM_W'(MAX_WIN);

  pll_state_e        state_q;
  logic [WIN_W-1:0]  win_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_last_q;
  logic [SET_W-1:0]  settle_q;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [LIM_W-1:0]  nwin_q, nwin_d;
  logic              pwrup_q, locked_q, fail_q;

  logic              edge_det;
  logic              counting, win_end, in_tol;
  logic [CNT_W:0]    diff, dev;

  sun_pll_tglsync u_tglsync (
    .clk_i  (CK_REF),
    .rst_ni (RST_N),
    .tgl_i  (DIV_TGL),
    .edge_o (edge_det)
  );

  // Window arithmetic: saturating edge count (including an edge landing on
  // the terminal cycle) and the absolute-deviation tolerance test
  always_comb begin
    counting = (state_q == ST_MEASURE) || (state_q == ST_LOCK);
    win_end  = (win_q == WIN_LAST);
    cnt_d    = cnt_q;
    if (edge_det && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    diff   = {1'b0, cnt_d} - {1'b0, TARGET};
    dev    = diff[CNT_W] ? -diff : diff;
    in_tol = (dev <= {1'b0, TOL});
    pass_d = in_tol ? pass_q + 1'b1 : '0;
    nwin_d = nwin_q + 1'b1;
  end

  // Controller state, window/edge/pass counters and registered outputs
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_OFF;
      win_q      <= '0;
      cnt_q      <= '0;
      cnt_last_q <= '0;
      settle_q   <= '0;
      pass_q     <= '0;
      nwin_q     <= '0;
      pwrup_q    <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      // A completed window is always published, even if EN drops this cycle
      if (counting && win_end) begin
        cnt_last_q <= cnt_d;
      end
      if (!EN) begin
        state_q  <= ST_OFF;
        win_q    <= '0;
        cnt_q    <= '0;
        settle_q <= '0;
        pass_q   <= '0;
        nwin_q   <= '0;
        pwrup_q  <= 1'b0;
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
      end else begin
        if (counting) begin
          if (win_end) begin
            win_q <= '0;
            cnt_q <= '0;
          end else begin
            win_q <= win_q + 1'b1;
            cnt_q <= cnt_d;
          end
        end
        unique case (state_q)
          ST_OFF: begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            pwrup_q  <= 1'b1;
          end
          ST_SETTLE: begin
            if (settle_q == SET_LAST) begin
              state_q  <= ST_MEASURE;
              settle_q <= '0;
              win_q    <= '0;
              cnt_q    <= '0;
              pass_q   <= '0;
              nwin_q   <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          ST_MEASURE: begin
            if (win_end) begin
              pass_q <= pass_d;
              nwin_q <= nwin_d;
              // Locking on the final allowed window wins over failing
              if (pass_d == PASS_N) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
              end else if (nwin_d == LIM_N) begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end
            end
          end
          ST_LOCK: begin
`ifdef SUN_PLL_CTRL_RELOCK_EN
            if (win_end && !in_tol) begin
              state_q  <= ST_MEASURE;
              locked_q <= 1'b0;
              pass_q   <= '0;
              nwin_q   <= '0;
            end
`endif
          end
          ST_FAIL: begin
          end
          default: begin
            state_q <= ST_OFF;
          end
        endcase
      end
    end
  end

  assign PWRUP_1V8 = pwrup_q;
  assign LOCKED    = locked_q;
  assign FAIL      = fail_q;
  assign CNT_LAST  = cnt_last_q;

endmodule

// File: doc/sun_pll_ctrl.md
SUN_PLL_CTRL -- requirements
Module: sun_pll_ctrl

Interface
REQ-001 Parameter WIN_CYC, default 256: length of one measurement window, in CK_REF cycles (≥16).
REQ-002 Parameter CNT_W, default 12: width of the edge counter, TARGET and TOL.
REQ-003 Parameter SETTLE_CYC, default 1024: CK_REF cycles spent in SETTLE after power-up.
REQ-004 Parameter LOCK_CONSEC, default 4: consecutive in-tolerance windows required to declare lock.
REQ-005 Parameter MAX_WIN, default 64: windows allowed in MEASURE before FAIL.
REQ-006 CK_REF  input  1: reference clock; the only clock of the block.
REQ-007 RST_N  input  1: reset, asynchronous assert, active-low.
REQ-008 EN  input  1: PLL enable request, synchronous to CK_REF.
REQ-009 DIV_TGL  input  1: asynchronous toggle from the PLL prescaler; its frequency is below CK_REF/4.
REQ-010 TARGET  input  CNT_W: expected DIV_TGL edge count per window.
REQ-011 TOL  input  CNT_W: allowed absolute deviation from TARGET.
REQ-012 PWRUP_1V8  output  1: power-up to the PLL core (CP, DIVN, ROSC, KICK).
REQ-013 LOCKED  output  1: frequency lock indication.
REQ-014 FAIL  output  1: lock timeout indication.
REQ-015 CNT_LAST  output  CNT_W: edge count of the last completed window.

Function
REQ-016 DIV_TGL SHALL pass through a 2-flop synchronizer; a third flop SHALL detect both edges; each detected edge SHALL increment the counter by 1.
REQ-017 The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-018 The window counter SHALL run 0..WIN_CYC-1 while in MEASURE or LOCKED; at terminal count the counter value SHALL load CNT_LAST and the counter SHALL clear, both in the same cycle.
REQ-019 A window SHALL be in tolerance when |count - TARGET| ≤ TOL, evaluated with CNT_W+1-bit arithmetic.
REQ-020 States: OFF, SETTLE, MEASURE, LOCK, FAIL.
REQ-021 OFF: PWRUP_1V8=0; on EN=1, go to SETTLE next cycle.
REQ-022 SETTLE: PWRUP_1V8=1; after SETTLE_CYC cycles, go to MEASURE with the window, edge and pass counters cleared.
REQ-023 MEASURE: an in-tolerance window increments the pass count and an out-of-tolerance window clears it; when the pass count reaches LOCK_CONSEC, go to LOCK.
REQ-024 MEASURE: when MAX_WIN windows complete without reaching LOCK, go to FAIL.
REQ-025 LOCK: LOCKED=1; PWRUP_1V8=1.
REQ-026 FAIL: FAIL=1; PWRUP_1V8=1; exits only via EN=0.
REQ-027 EN=0 in any state SHALL go to OFF next cycle and clear all counters; LOCKED and FAIL SHALL drop in that same cycle.
REQ-028 Lock is declared on the same cycle as the window boundary: LOCKED SHALL rise the cycle after the terminal count of the LOCK_CONSEC-th passing window.
REQ-029 If EN falls on a window-boundary cycle, EN=0 SHALL take priority; CNT_LAST still updates.
REQ-030 LOCKED, FAIL and PWRUP_1V8 SHALL be driven directly from registers.

Reset
REQ-031 RST_N=0 SHALL force state OFF, PWRUP_1V8=0, LOCKED=0, FAIL=0, CNT_LAST=0, all counters 0 and all synchronizer flops 0.
REQ-032 RST_N deassertion SHALL be synchronized externally; the block SHALL resume in OFF regardless of EN.

Configuration
REQ-033 Macro SUN_PLL_CTRL_RELOCK_EN defined: in LOCK, windows continue; one out-of-tolerance window drops LOCKED and returns to MEASURE with the pass and window-limit counts cleared.
REQ-034 SUN_PLL_CTRL_RELOCK_EN undefined: LOCKED is sticky until EN=0 or reset, and window comparison stops in LOCK.

Structure
REQ-035 Package sun_pll_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module sun_pll_tglsync SHALL contain the 2-flop synchronizer and the edge detector.

Verification
REQ-037 Reset with EN=1 held; release RST_N -> SETTLE follows OFF after 1 cycle; PWRUP_1V8 rises; MEASURE is entered after 1024 cycles.
REQ-038 DIV_TGL at CK_REF/8, TARGET=64, TOL=2 -> CNT_LAST=64 each window; LOCKED rises exactly 4 windows after MEASURE entry.
REQ-039 DIV_TGL at CK_REF/16, TARGET=64, TOL=2 -> CNT_LAST=32; FAIL rises after 64 windows; LOCKED stays 0.
REQ-040 Counts 64,64,70,64,64,64,64 -> pass count clears on the 70; LOCKED rises after the 7th window.
REQ-041 In LOCK, drive CK_REF/16 -> with RELOCK_EN, LOCKED falls after one window; without RELOCK_EN, LOCKED stays 1.
REQ-042 EN dropped mid-window and on a boundary cycle; separately, RST_N pulsed in LOCK -> OFF the next cycle (or immediately, for reset), all outputs 0, CNT_LAST behaving per REQ-029 and REQ-031.
